ff_chain_rr_arbiter: RTL and testbench
======================================

// Module: ff_chain_rr_arbiter
// PURPOSE
//  Shares one stallable flip-flop delay chain between NREQ requesters.
//  - Round-robin arbitration; a multi-beat burst holds the grant until its last beat.
//  - The accepted beat is tagged with requester id and last flag, then pushed into a CHAIN_NUM-deep pipe.
//  - Beats emerge on a valid/ready output port. Sits between producer lanes and a shared delay/retime path.
// PARAMETERS
//  DW         8   data width per beat (>=1)
//  CHAIN_NUM  2   pipe depth = nominal latency in cycles (>=1)
//  NREQ       4   number of requesters (>=2)
//  IDW        $clog2(NREQ), localparam; requester id width
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         synchronous reset, active-high
//  req_valid  in   NREQ      beat offered by requester i
//  req_last   in   NREQ      offered beat is the last of its burst
//  req_data   in   NREQ*DW   beat data; lane i = [i*DW +: DW]
//  req_ready  out  NREQ      beat of requester i accepted this cycle (one-hot or zero)
//  out_valid  out  1         pipe output beat valid
//  out_data   out  DW        output beat data
//  out_id     out  IDW       requester id of output beat
//  out_last   out  1         last flag of output beat
//  out_ready  in   1         downstream accepts output beat
//  busy       out  1         any pipe stage valid OR state == ST_BURST
// BEHAVIOUR
//  Reset
//  - All stage valid/data/id/last = 0; out_* = 0; req_ready = 0; busy = 0.
//  - state = ST_ARB; rr_ptr = 0.
//  - Reset mid-burst or with beats in flight drops all of them; no partial flush.
//  Stall
//  - stall = out_valid & ~out_ready (combinational).
//  - While stall: the whole pipe holds; out_* stay stable; req_ready = 0.
//  - Bubbles (invalid stages) never stall.
//  Advance
//  - Every non-stall cycle the pipe shifts by one.
//  - Stage0 loads {1, id, last, data} on accept, else {0, 0, 0, 0}.
//  - Latency accept -> out_valid = CHAIN_NUM cycles + number of stall cycles.
//  ST_ARB
//  - If !stall and |req_valid: winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, .. mod NREQ.
//  - req_ready[winner] = 1 that cycle (ready may depend on valid; valid must not depend on ready).
//  - Winner with last = 1: stay ST_ARB; rr_ptr <= (winner+1) mod NREQ, wrapping NREQ-1 -> 0.
//  - Winner with last = 0: -> ST_BURST; lock_id <= winner.
//  ST_BURST
//  - Only lock_id is served: req_ready[lock_id] = !stall & req_valid[lock_id]; all others 0.
//  - Locked requester idle: insert a bubble, stay ST_BURST; no timeout.
//  - Accepted beat with last = 1: -> ST_ARB; rr_ptr <= (lock_id+1) mod NREQ.
//  Other rules
//  - Simultaneous stall + request: no accept; arbitration is re-evaluated next cycle with the same rr_ptr.
//  - Widths: id zero-extended to IDW; no arithmetic on data.
// STRUCTURE
//  - Package ff_chain_arb_pkg: typedef enum logic {ST_ARB, ST_BURST} arb_state_e.
//  - Package ff_chain_arb_pkg: function rr_pick(valid, ptr) returning winner index and a found flag.
//  - Sub-module ff_chain_stall_pipe #(W, CHAIN_NUM): W-bit shift chain with
//    synchronous active-high rst and an advance enable.
//  - Arbiter carries W = 1 + IDW + 1 + DW through it.
// TESTING
//  - Reset: assert rst 2 cycles with all req_valid = 1 -> req_ready = 0, out_valid = 0, busy = 0; first grant after release goes to id 0.
//  - Single beats: req 0..3 all valid, last = 1, data = 8'hA0+i, out_ready = 1
//    -> grants 0, 1, 2, 3, 0 in order; out_id = 0 with 8'hA0 appears 2 cycles after accept.
//  - Burst lock: req1 sends 3 beats (last on the 3rd) while req2 stays valid
//    -> req2 waits until req1's last is accepted; req2 is granted next; out_last only on the 3rd beat.
//  - Backpressure: out_ready = 0 for 4 cycles with pipe full
//    -> out_* stable, req_ready = 0; no beats lost or duplicated; order is preserved.
//  - Burst bubble: req3 drops valid for 2 cycles mid-burst
//    -> two invalid beats are inserted; state stays ST_BURST; other requesters get no grant.
//  - Mid-burst reset: rst asserted during req2's burst with pipe full -> next cycle all outputs 0, state ST_ARB, rr_ptr 0.

Source files
------------

// File: rtl/ff_chain_arb_pkg.sv
// rtl/ff_chain_arb_pkg.sv - shared state type and round-robin pick helper for the chain arbiter
package ff_chain_arb_pkg;

    typedef enum logic {ST_ARB = 1'b0, ST_BURST = 1'b1} arb_state_e;

    localparam int MAX_NREQ = 32;
    localparam int MAX_IDW  = 5;

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] idx;
    } rr_pick_t;

    // First set bit of valid scanning ptr, ptr+1, .. wrapping modulo nreq
    function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                         input logic [MAX_IDW-1:0]  ptr,
                                         input int                  nreq);
        rr_pick_t           res;
        int                 k;
        logic [MAX_IDW-1:0] k_idx;
        res = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            k     = (int'(ptr) + i) % nreq;
            k_idx = k[MAX_IDW-1:0];
            if (i < nreq && !res.found && valid[k_idx]) begin
                res.found = 1'b1;
                res.idx   = k_idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ff_chain_stall_pipe.sv
// rtl/ff_chain_stall_pipe.sv - W-bit shift chain that moves only when advance is high
module ff_chain_stall_pipe #(
    parameter int W         = 8,
    parameter int CHAIN_NUM = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance,
    input  logic [W-1:0]         in_data,
    output logic [W-1:0]         out_data,
    output logic [CHAIN_NUM-1:0] stage_msb
);

    logic [W-1:0] stage_q [CHAIN_NUM];
    logic [W-1:0] stage_d [CHAIN_NUM];

    always_comb begin
        for (int i = 0; i < CHAIN_NUM; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (advance) begin
            stage_d[0] = in_data;
            for (int i = 1; i < CHAIN_NUM; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHAIN_NUM; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_data = stage_q[CHAIN_NUM-1];

    always_comb begin
        for (int i = 0; i < CHAIN_NUM; i++) begin
            stage_msb[i] = stage_q[i][W-1];
        end
    end

endmodule

// File: rtl/ff_chain_rr_arbiter.sv
// rtl/ff_chain_rr_arbiter.sv - round-robin burst arbiter feeding a stallable delay chain
module ff_chain_rr_arbiter
    import ff_chain_arb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int CHAIN_NUM = 2,
    parameter int NREQ      = 4,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_last,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [IDW-1:0]     out_id,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy
);

    localparam int W = 1 + IDW + 1 + DW;

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;

    logic                 stall;
    logic                 accept;
    logic [IDW-1:0]       acc_id;
    logic [IDW-1:0]       winner;
    rr_pick_t             pick;
    logic [W-1:0]         pipe_in;
    logic [W-1:0]         pipe_out;
    logic [CHAIN_NUM-1:0] stage_valid;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(NREQ-1)) ? '0 : id + IDW'(1);
    endfunction

    assign stall  = out_valid & ~out_ready;
    assign pick   = rr_pick(MAX_NREQ'(req_valid), MAX_IDW'(rr_ptr_q), NREQ);
    assign winner = pick.idx[IDW-1:0];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        accept    = 1'b0;
        acc_id    = '0;
        if (!rst && !stall) begin
            case (state_q)
                ST_ARB: begin
                    if (pick.found) begin
                        accept = 1'b1;
                        acc_id = winner;
                        if (req_last[winner]) begin
                            rr_ptr_d = next_id(winner);
                        end else begin
                            state_d   = ST_BURST;
                            lock_id_d = winner;
                        end
                    end
                end
                ST_BURST: begin
                    // An idle locked requester simply leaves a bubble; the lock never times out
                    if (req_valid[lock_id_q]) begin
                        accept = 1'b1;
                        acc_id = lock_id_q;
                        if (req_last[lock_id_q]) begin
                            state_d  = ST_ARB;
                            rr_ptr_d = next_id(lock_id_q);
                        end
                    end
                end
                default: state_d = ST_ARB;
            endcase
        end
    end

    always_comb begin
        req_ready = accept ? (NREQ'(1) << acc_id) : '0;
        pipe_in   = '0;
        if (accept) begin
            pipe_in = {1'b1, acc_id, req_last[acc_id], req_data[int'(acc_id)*DW +: DW]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ARB;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    ff_chain_stall_pipe #(
        .W         (W),
        .CHAIN_NUM (CHAIN_NUM)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .advance   (~stall),
        .in_data   (pipe_in),
        .out_data  (pipe_out),
        .stage_msb (stage_valid)
    );

    // Beat layout through the chain: {valid, id, last, data}
    assign out_valid = pipe_out[W-1];
    assign out_id    = pipe_out[W-2 -: IDW];
    assign out_last  = pipe_out[DW];
    assign out_data  = pipe_out[DW-1:0];
    assign busy      = (|stage_valid) | (state_q == ST_BURST);

endmodule

// File: tb/tb_ff_chain_rr_arbiter.sv
// tb/tb_ff_chain_rr_arbiter.sv - directed and random checks of the chain arbiter against a beat-level model
module tb_ff_chain_rr_arbiter;
    import ff_chain_arb_pkg::*;

    localparam int DW        = 8;
    localparam int CHAIN_NUM = 2;
    localparam int NREQ      = 4;
    localparam int IDW       = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_last;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [IDW-1:0]     out_id;
    logic               out_last;
    logic               out_ready;
    logic               busy;

    always #5 clk = ~clk;

    ff_chain_rr_arbiter #(.DW(DW), .CHAIN_NUM(CHAIN_NUM), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    typedef struct {
        bit v;
        int id;
        bit l;
        int d;
    } beat_t;

    beat_t mp [CHAIN_NUM];
    int    ptr;
    int    lock;
    int    rem  [NREQ];
    int    blen [NREQ];
    bit    rand_len;
    bit    chk_en;
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int new_len(input int i);
        return rand_len ? int'($urandom_range(1, 4)) : blen[i];
    endfunction

    function automatic int predict();
        if (rst || (mp[CHAIN_NUM-1].v && !out_ready)) return -1;
        if (lock >= 0) return req_valid[lock] ? lock : -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < CHAIN_NUM; i++) mp[i] = '{0, 0, 0, 0};
        ptr  = 0;
        lock = -1;
        for (int i = 0; i < NREQ; i++) rem[i] = new_len(i);
    endtask

    task automatic drive(input logic [NREQ-1:0] mask, input bit fixed_data);
        req_valid = mask;
        for (int i = 0; i < NREQ; i++) begin
            req_last[i]           = (rem[i] == 1);
            req_data[i*DW +: DW]  = fixed_data ? DW'(8'hA0 + i) : DW'($urandom);
        end
        #1;
    endtask

    task automatic step();
        int g;
        int exp_busy;
        #1;
        g        = predict();
        exp_busy = (lock >= 0) ? 1 : 0;
        for (int i = 0; i < CHAIN_NUM; i++) if (mp[i].v) exp_busy = 1;
        if (chk_en) begin
            chk("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
            chk("out_valid", int'(out_valid), int'(mp[CHAIN_NUM-1].v));
            chk("out_id",    int'(out_id),    mp[CHAIN_NUM-1].id);
            chk("out_last",  int'(out_last),  int'(mp[CHAIN_NUM-1].l));
            chk("out_data",  int'(out_data),  mp[CHAIN_NUM-1].d);
            chk("busy",      int'(busy),      exp_busy);
        end
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (!(mp[CHAIN_NUM-1].v && !out_ready)) begin
            for (int i = CHAIN_NUM - 1; i > 0; i--) mp[i] = mp[i-1];
            if (g >= 0) begin
                mp[0] = '{1, g, req_last[g], int'(req_data[g*DW +: DW])};
                if (req_last[g]) begin
                    ptr  = (g + 1) % NREQ;
                    lock = -1;
                end else begin
                    lock = g;
                end
                rem[g]--;
                if (rem[g] <= 0) rem[g] = new_len(g);
            end else begin
                mp[0] = '{0, 0, 0, 0};
            end
        end
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        rand_len  = 0;
        chk_en    = 0;
        for (int i = 0; i < NREQ; i++) blen[i] = 1;
        model_clear();
        @(posedge clk);
        #1;

        // Reset with every requester asking: nothing granted, nothing in flight
        drive(4'hF, 1);
        step();
        chk_en = 1;
        step();
        step();
        rst = 1'b0;

        // Single-beat round robin with fixed data A0+i
        for (int s = 0; s < 6; s++) begin
            drive(4'hF, 1);
            if (s == 0) chk("first_grant_id0", int'(req_ready), 1);
            if (s == 2) begin
                chk("a0_out_valid", int'(out_valid), 1);
                chk("a0_out_id",    int'(out_id),    0);
                chk("a0_out_data",  int'(out_data),  'hA0);
            end
            step();
        end

        // Requester 1 holds a 3-beat burst while requester 2 waits
        rem[1] = 3;
        blen[1] = 3;
        for (int s = 0; s < 8; s++) begin
            drive(4'b0010 | ((s > 0) ? 4'b0100 : 4'b0000), 0);
            step();
        end
        blen[1] = 1;
        rem[1]  = 1;

        // Backpressure with a full pipe
        for (int s = 0; s < 11; s++) begin
            out_ready = (s < 3 || s >= 7);
            drive(4'hF, 0);
            step();
        end

        // Requester 3 goes idle mid-burst; others must not be served meanwhile
        blen[3] = 4;
        rem[3]  = 4;
        for (int s = 0; s < 8; s++) begin
            drive((s == 2 || s == 3) ? 4'b0111 : 4'b1000, 0);
            if (s == 2 || s == 3) chk("bubble_no_grant", int'(req_ready), 0);
            step();
        end
        blen[3] = 1;

        // Reset in the middle of a requester 2 burst
        blen[2] = 5;
        rem[2]  = 5;
        for (int s = 0; s < 3; s++) begin
            drive(4'b0100, 0);
            step();
        end
        rst = 1'b1;
        drive(4'b0100, 0);
        step();
        rst = 1'b0;
        blen[2] = 1;
        for (int i = 0; i < NREQ; i++) rem[i] = 1;
        drive(4'b0000, 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_state",     int'(dut.state_q),  int'(ST_ARB));
        chk("rst_rr_ptr",    int'(dut.rr_ptr_q), 0);
        step();

        // Random traffic, burst lengths and backpressure
        rand_len = 1;
        for (int i = 0; i < NREQ; i++) rem[i] = new_len(i);
        for (int s = 0; s < 400; s++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive(NREQ'($urandom_range(0, 15)), 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
